wb_retire_stage: RTL and testbench

Parametrised multi-lane writeback/retire stage, successor to the single-lane writeback register. Sits between the memory stage and the register file: accepts a retire bundle of `LANES` results under a valid/ready handshake, formats load data, and absorbs register-file backpressure with a two-entry skid buffer. It also resolves same-bundle write conflicts, suppresses x0 writes, and keeps a retired-instruction counter.

---
 rtl/wb_pkg.sv | 23 ++
 rtl/wb_load_align.sv | 39 +++
 rtl/wb_retire_stage.sv | 137 +++++++++++++
 tb/tb_wb_retire_stage.sv | 318 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/wb_pkg.sv
`default_nettype none
// ============================================================================
// wb_pkg : load funct3 codes, default widths and retire-bundle width helper
// Revision: 1.0
// ============================================================================
package wb_pkg;

  localparam logic [2:0] LD_B  = 3'b000;
  localparam logic [2:0] LD_H  = 3'b001;
  localparam logic [2:0] LD_W  = 3'b010;
  localparam logic [2:0] LD_BU = 3'b100;
  localparam logic [2:0] LD_HU = 3'b101;

  localparam int XLEN_DEF = 32;
  localparam int RA_W_DEF = 5;

  // Stored bundle per lane: lane_vld + rd_wen + rd + formatted data.
  function automatic int bundle_w(input int lanes, input int xlen, input int ra_w);
    return lanes * (xlen + ra_w + 2);
  endfunction

endpackage
`default_nettype wire

// File: rtl/wb_load_align.sv
`default_nettype none
// ============================================================================
// wb_load_align : one-lane load formatter (byte/half select and extension)
// Revision: 1.0
// ============================================================================
module wb_load_align
  import wb_pkg::*;
#(
  parameter int XLEN = XLEN_DEF
) (
  input  logic [XLEN-1:0] data,
  input  logic            en,
  input  logic [2:0]      fmt,
  input  logic [1:0]      off,
  output logic [XLEN-1:0] result
);

  logic [7:0]  byte_sel;
  logic [15:0] half_sel;

  always_comb begin
    byte_sel = data[{off, 3'b000} +: 8];
    // Halfword lanes are naturally aligned; the low offset bit is ignored.
    half_sel = data[{off[1], 4'b0000} +: 16];
    result   = data;
    if (en) begin
      case (fmt)
        LD_B:    result = {{(XLEN-8){byte_sel[7]}}, byte_sel};
        LD_BU:   result = {{(XLEN-8){1'b0}}, byte_sel};
        LD_H:    result = {{(XLEN-16){half_sel[15]}}, half_sel};
        LD_HU:   result = {{(XLEN-16){1'b0}}, half_sel};
        LD_W:    result = data;
        default: result = data;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: rtl/wb_retire_stage.sv
`default_nettype none
// ============================================================================
// wb_retire_stage : multi-lane writeback/retire stage with 2-entry skid buffer,
//                   WAW resolution, x0 suppression and retire counter
// Revision: 1.0
// ============================================================================
module wb_retire_stage
  import wb_pkg::*;
#(
  parameter int XLEN  = XLEN_DEF,
  parameter int LANES = 2,
  parameter int RA_W  = RA_W_DEF,
  parameter int CNT_W = 64
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  flush,
  input  logic                  in_valid,
  output logic                  in_ready,
  input  logic [LANES-1:0]      in_lane_vld,
  input  logic [LANES*RA_W-1:0] in_rd,
  input  logic [LANES-1:0]      in_rd_wen,
  input  logic [LANES*XLEN-1:0] in_wb_data,
  input  logic [LANES-1:0]      in_ld_en,
  input  logic [LANES*3-1:0]    in_ld_fmt,
  input  logic [LANES*2-1:0]    in_ld_off,
  input  logic                  rf_ready,
  output logic [LANES-1:0]      rf_we,
  output logic [LANES*RA_W-1:0] rf_waddr,
  output logic [LANES*XLEN-1:0] rf_wdata,
  output logic [CNT_W-1:0]      retire_cnt
);

  localparam int BW      = bundle_w(LANES, XLEN, RA_W);
  localparam int DATA_LSB = 0;
  localparam int RD_LSB   = LANES * XLEN;
  localparam int WEN_LSB  = RD_LSB + LANES * RA_W;
  localparam int VLD_LSB  = WEN_LSB + LANES;

  logic [LANES*XLEN-1:0] fmt_data;
  logic [BW-1:0]         in_bundle;
  logic [BW-1:0]         out_q;
  logic [BW-1:0]         skid_q;
  logic                  out_v;
  logic                  skid_v;
  logic [CNT_W-1:0]      cnt_q;
  logic                  accept;
  logic                  commit;

  logic [LANES-1:0]      out_lv;
  logic [LANES-1:0]      out_wen;
  logic [LANES*RA_W-1:0] out_rd;
  logic [LANES-1:0]      qual;
  logic [CNT_W-1:0]      pop;

  for (genvar i = 0; i < LANES; i++) begin : g_align
    wb_load_align #(.XLEN(XLEN)) u_align (
      .data   (in_wb_data[i*XLEN +: XLEN]),
      .en     (in_ld_en[i]),
      .fmt    (in_ld_fmt[i*3 +: 3]),
      .off    (in_ld_off[i*2 +: 2]),
      .result (fmt_data[i*XLEN +: XLEN])
    );
  end

  assign in_bundle = {in_lane_vld, in_rd_wen, in_rd, fmt_data};

  assign in_ready = ~skid_v;
  assign accept   = in_valid & in_ready & ~flush;
  assign commit   = out_v & rf_ready & ~flush & ~rst;

  assign out_lv  = out_q[VLD_LSB +: LANES];
  assign out_wen = out_q[WEN_LSB +: LANES];
  assign out_rd  = out_q[RD_LSB +: LANES*RA_W];

  // Skid entry is only ever filled while the output register is stalled,
  // so a commit with skid valid never coincides with an accept.
  always_ff @(posedge clk) begin
    if (rst) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
      out_q  <= '0;
      skid_q <= '0;
      cnt_q  <= '0;
    end else if (flush) begin
      out_v  <= 1'b0;
      skid_v <= 1'b0;
    end else begin
      if (commit) begin
        cnt_q <= cnt_q + pop;
      end
      if (commit && skid_v) begin
        out_q  <= skid_q;
        skid_v <= 1'b0;
      end else if (accept && (!out_v || commit)) begin
        out_q <= in_bundle;
        out_v <= 1'b1;
      end else if (accept) begin
        skid_q <= in_bundle;
        skid_v <= 1'b1;
      end else if (commit) begin
        out_v <= 1'b0;
      end
    end
  end

  // Highest lane wins a write-after-write conflict on the same rd.
  for (genvar i = 0; i < LANES; i++) begin : g_waw
    logic [RA_W-1:0] rd_i;
    logic            shadowed;

    assign rd_i    = out_rd[i*RA_W +: RA_W];
    assign qual[i] = out_lv[i] & out_wen[i] & (rd_i != '0);

    always_comb begin
      shadowed = 1'b0;
      for (int j = i + 1; j < LANES; j++) begin
        if (qual[j] && (out_rd[j*RA_W +: RA_W] == rd_i)) shadowed = 1'b1;
      end
    end

    assign rf_we[i] = commit & qual[i] & ~shadowed;
  end

  always_comb begin
    pop = '0;
    for (int i = 0; i < LANES; i++) begin
      pop = pop + CNT_W'(out_lv[i]);
    end
  end

  assign rf_waddr   = out_rd;
  assign rf_wdata   = out_q[DATA_LSB +: LANES*XLEN];
  assign retire_cnt = cnt_q;

endmodule
`default_nettype wire

// File: tb/tb_wb_retire_stage.sv
`default_nettype none
// ============================================================================
// tb_wb_retire_stage : directed + randomized bench against a queue-based model
// Revision: 1.0
// ============================================================================
module tb_wb_retire_stage;

  logic        clk = 1'b0;
  logic        rst, flush, in_valid, rf_ready;
  logic        in_ready;
  logic [1:0]  in_lane_vld, in_rd_wen, in_ld_en;
  logic [9:0]  in_rd;
  logic [63:0] in_wb_data;
  logic [5:0]  in_ld_fmt;
  logic [3:0]  in_ld_off;
  logic [1:0]  rf_we;
  logic [9:0]  rf_waddr;
  logic [63:0] rf_wdata;
  logic [3:0]  retire_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  wb_retire_stage #(.XLEN(32), .LANES(2), .RA_W(5), .CNT_W(4)) dut (
    .clk(clk), .rst(rst), .flush(flush),
    .in_valid(in_valid), .in_ready(in_ready),
    .in_lane_vld(in_lane_vld), .in_rd(in_rd), .in_rd_wen(in_rd_wen),
    .in_wb_data(in_wb_data), .in_ld_en(in_ld_en), .in_ld_fmt(in_ld_fmt),
    .in_ld_off(in_ld_off), .rf_ready(rf_ready),
    .rf_we(rf_we), .rf_waddr(rf_waddr), .rf_wdata(rf_wdata),
    .retire_cnt(retire_cnt)
  );

  // Model: the stage is a 2-deep FIFO whose head is presented to the RF.
  typedef struct {
    logic [1:0]  lv;
    logic [1:0]  wen;
    logic [9:0]  rd;
    logic [63:0] data;
  } bund_t;

  bund_t       q[$];
  int          m_cnt = 0;
  logic [9:0]  shown_rd = '0;
  logic [63:0] shown_data = '0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s at %0t: got %0h expected %0h", name, $time, act, exp);
    end
  endtask

  function automatic logic [31:0] fmt_word(input logic [31:0] raw, input logic [2:0] f,
                                           input logic [1:0] o);
    logic [31:0] b, h;
    b = (raw >> (8 * o)) & 32'hFF;
    h = (raw >> (o[1] ? 16 : 0)) & 32'hFFFF;
    case (f)
      3'd0: return (b >= 32'h80) ? (b | 32'hFFFF_FF00) : b;
      3'd4: return b;
      3'd1: return (h >= 32'h8000) ? (h | 32'hFFFF_0000) : h;
      3'd5: return h;
      default: return raw;
    endcase
  endfunction

  task automatic sample();
    logic [1:0] exp_we;
    @(negedge clk);
    #1;
    exp_we = 2'b00;
    if (!rst && !flush && rf_ready && q.size() > 0) begin
      for (int i = 0; i < 2; i++) begin
        logic [4:0] ri;
        logic       ok;
        ri = q[0].rd[i*5 +: 5];
        ok = q[0].lv[i] && q[0].wen[i] && (ri != 0);
        for (int j = i + 1; j < 2; j++)
          if (q[0].lv[j] && q[0].wen[j] && q[0].rd[j*5 +: 5] == ri) ok = 1'b0;
        exp_we[i] = ok;
      end
    end
    chk("rf_we", 64'(rf_we), 64'(exp_we));
    if (!rst) begin
      chk("in_ready", 64'(in_ready), 64'(q.size() < 2));
      chk("rf_waddr", 64'(rf_waddr), 64'(shown_rd));
      chk("rf_wdata", rf_wdata, shown_data);
      chk("retire_cnt", 64'(retire_cnt), 64'(m_cnt));
    end
  endtask

  task automatic advance();
    bit    do_commit, do_acc;
    bund_t b;
    if (rst) begin
      q.delete();
      m_cnt = 0;
      shown_rd = '0;
      shown_data = '0;
    end else if (flush) begin
      q.delete();
    end else begin
      do_commit = (q.size() > 0) && rf_ready;
      do_acc    = in_valid && (q.size() < 2);
      if (do_commit) begin
        m_cnt = (m_cnt + int'(q[0].lv[0]) + int'(q[0].lv[1])) % 16;
        void'(q.pop_front());
      end
      if (do_acc) begin
        b.lv  = in_lane_vld;
        b.wen = in_rd_wen;
        b.rd  = in_rd;
        for (int i = 0; i < 2; i++)
          b.data[i*32 +: 32] = in_ld_en[i] ?
            fmt_word(in_wb_data[i*32 +: 32], in_ld_fmt[i*3 +: 3], in_ld_off[i*2 +: 2]) :
            in_wb_data[i*32 +: 32];
        q.push_back(b);
      end
      if (q.size() > 0) begin
        shown_rd   = q[0].rd;
        shown_data = q[0].data;
      end
    end
    @(posedge clk);
    #1;
  endtask

  task automatic tick();
    sample();
    advance();
  endtask

  task automatic idle(input logic rr);
    rst = 0; flush = 0; in_valid = 0; in_lane_vld = 0; in_rd_wen = 0; in_rd = 0;
    in_wb_data = 0; in_ld_en = 0; in_ld_fmt = 0; in_ld_off = 0; rf_ready = rr;
  endtask

  task automatic put(input logic [1:0] lv, input logic [1:0] wen, input logic [9:0] rd,
                     input logic [63:0] wd, input logic rr);
    idle(rr);
    in_valid = 1; in_lane_vld = lv; in_rd_wen = wen; in_rd = rd; in_wb_data = wd;
  endtask

  task automatic do_reset();
    idle(1'b1);
    rst = 1;
    tick();
    tick();
    idle(1'b1);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    logic [2:0]  lf[4];
    logic [1:0]  lo[4];
    logic [31:0] lexp[4];
    lf   = '{3'd0, 3'd4, 3'd1, 3'd5};
    lo   = '{2'd2, 2'd3, 2'd1, 2'd2};
    lexp = '{32'hFFFF_FFFF, 32'h0000_0080, 32'h0000_7F01, 32'h0000_80FF};

    idle(1'b1);
    rst = 1;
    @(posedge clk);
    #1;
    do_reset();
    sample();
    chk("reset_in_ready", 64'(in_ready), 64'd1);
    chk("reset_cnt", 64'(retire_cnt), 64'd0);
    chk("reset_wdata", rf_wdata, 64'd0);
    advance();

    // Basic two-lane retire.
    put(2'b11, 2'b11, {5'd4, 5'd3}, {32'h22, 32'h11}, 1'b1);
    tick();
    idle(1'b1);
    sample();
    chk("basic_we", 64'(rf_we), 64'h3);
    chk("basic_addr", 64'(rf_waddr), 64'({5'd4, 5'd3}));
    chk("basic_data", rf_wdata, {32'h22, 32'h11});
    advance();
    sample();
    chk("basic_cnt", 64'(retire_cnt), 64'd2);
    advance();

    // Load formatting on lane 0.
    for (int k = 0; k < 4; k++) begin
      put(2'b01, 2'b01, {5'd0, 5'd1}, {32'h0, 32'h80FF_7F01}, 1'b1);
      in_ld_en  = 2'b01;
      in_ld_fmt = {3'b000, lf[k]};
      in_ld_off = {2'b00, lo[k]};
      tick();
      idle(1'b1);
      sample();
      chk("load_fmt", 64'(rf_wdata[31:0]), 64'(lexp[k]));
      advance();
    end

    // WAW: both lanes target x5, lane 1 wins.
    put(2'b11, 2'b11, {5'd5, 5'd5}, {32'hB, 32'hA}, 1'b1);
    tick();
    idle(1'b1);
    sample();
    chk("waw_we", 64'(rf_we), 64'h2);
    chk("waw_data", 64'(rf_wdata[63:32]), 64'hB);
    advance();

    // x0 write suppressed, non-writing lane still counted by the model.
    put(2'b11, 2'b01, {5'd7, 5'd0}, {32'h5, 32'h6}, 1'b1);
    tick();
    idle(1'b1);
    sample();
    chk("x0_we", 64'(rf_we), 64'h0);
    advance();
    tick();

    // Backpressure: B0..B3 with rf_ready low for 3 cycles.
    put(2'b11, 2'b11, {5'd20, 5'd10}, {32'h200, 32'h100}, 1'b0);
    tick();
    put(2'b11, 2'b11, {5'd21, 5'd11}, {32'h201, 32'h101}, 1'b0);
    tick();
    put(2'b11, 2'b11, {5'd22, 5'd12}, {32'h202, 32'h102}, 1'b0);
    sample();
    chk("bp_in_ready", 64'(in_ready), 64'd0);
    chk("bp_head", 64'(rf_waddr[4:0]), 64'd10);
    advance();
    rf_ready = 1'b1;
    sample();
    chk("bp_c0", 64'(rf_waddr[4:0]), 64'd10);
    advance();
    sample();
    chk("bp_c1", 64'(rf_waddr[4:0]), 64'd11);
    advance();
    put(2'b11, 2'b11, {5'd23, 5'd13}, {32'h203, 32'h103}, 1'b1);
    sample();
    chk("bp_c2", 64'(rf_waddr[4:0]), 64'd12);
    advance();
    idle(1'b1);
    sample();
    chk("bp_c3", 64'(rf_waddr[4:0]), 64'd13);
    chk("bp_c3_we", 64'(rf_we), 64'h3);
    advance();
    tick();

    // Flush with both entries full.
    put(2'b11, 2'b11, {5'd2, 5'd1}, {32'h2, 32'h1}, 1'b0);
    tick();
    put(2'b11, 2'b11, {5'd4, 5'd3}, {32'h4, 32'h3}, 1'b0);
    tick();
    put(2'b11, 2'b11, {5'd6, 5'd5}, {32'h6, 32'h5}, 1'b1);
    flush = 1'b1;
    sample();
    chk("flush_we", 64'(rf_we), 64'h0);
    advance();
    idle(1'b1);
    sample();
    chk("flush_in_ready", 64'(in_ready), 64'd1);
    chk("flush_we_after", 64'(rf_we), 64'h0);
    advance();

    // Reset mid-stream.
    put(2'b11, 2'b11, {5'd9, 5'd8}, {32'h9, 32'h8}, 1'b0);
    tick();
    put(2'b11, 2'b11, {5'd9, 5'd8}, {32'h9, 32'h8}, 1'b0);
    tick();
    rst = 1'b1;
    rf_ready = 1'b1;
    tick();
    idle(1'b1);
    sample();
    chk("rst_we", 64'(rf_we), 64'h0);
    chk("rst_addr", 64'(rf_waddr), 64'd0);
    chk("rst_data", rf_wdata, 64'd0);
    chk("rst_cnt", 64'(retire_cnt), 64'd0);
    chk("rst_in_ready", 64'(in_ready), 64'd1);
    advance();

    // Counter wrap: 8 two-lane bundles + 1 one-lane bundle = 17 -> 1 (mod 16).
    for (int k = 0; k < 9; k++) begin
      put((k == 8) ? 2'b01 : 2'b11, 2'b00, 10'd0, 64'd0, 1'b1);
      tick();
    end
    idle(1'b1);
    tick();
    sample();
    chk("wrap_cnt", 64'(retire_cnt), 64'd1);
    advance();

    // Randomized traffic.
    for (int n = 0; n < 1500; n++) begin
      rst         = ($urandom % 150) == 0;
      flush       = ($urandom % 25) == 0;
      in_valid    = ($urandom % 4) != 0;
      in_lane_vld = 2'($urandom);
      in_rd_wen   = 2'($urandom);
      in_rd       = {5'($urandom_range(0, 3)), 5'($urandom_range(0, 3))};
      in_wb_data  = {$urandom, $urandom};
      in_ld_en    = 2'($urandom);
      in_ld_fmt   = 6'($urandom);
      in_ld_off   = 4'($urandom);
      rf_ready    = ($urandom % 3) != 0;
      tick();
    end

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
`default_nettype wire
